remote_cmd_arbiter: RTL and testbench
=====================================

Name: remote_cmd_arbiter

Overview:
Shares one RemoteComm command channel (16-bit cmd out, 8-bit response back) among NUM_REQ requesters, e.g. bench tour driver, calibration sequencer and manual-jog source. Round-robin arbitration; one transaction in flight at a time. A transaction is: issue snd_cmd, wait for cmd_snt, wait for the response byte or timeout, return the response to the winning requester. Sits between the requesters and RemoteComm in the remote/bench-side hierarchy.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
TIMEOUT_CYCLES, 1_000_000, clk cycles from snd_cmd to abandon (20 ms @ 50 MHz).

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request level
req_cmd  input  16*NUM_REQ  per-requester command; slice i = bits [16*i+15:16*i]
gnt  output  NUM_REQ  one-hot grant, held for the whole transaction
done  output  NUM_REQ  one-cycle completion pulse to the granted requester
resp_out  output  8  response byte, valid while any done bit is high
timed_out  output  1  high with done when the transaction timed out
busy  output  1  high in any state other than IDLE
snd_cmd  output  1  one-cycle pulse to RemoteComm
cmd  output  16  command to RemoteComm, registered, stable for the whole transaction
cmd_snt  input  1  RemoteComm level: both bytes sent
resp  input  8  RemoteComm response byte
resp_rdy  input  1  RemoteComm response-ready level

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; gnt, done, snd_cmd, timed_out, busy = 0; resp_out=0; cmd=0.
  - RR pointer = NUM_REQ-1, so req[0] has highest priority first.
  - resp_rdy_q=0; timeout counter=0.
  - A reset mid-transaction abandons it with no done pulse.
- States: IDLE, ISSUE, WAIT_SNT, WAIT_RESP, DONE.
- IDLE: if any req bit is high:
  - pick the first set index scanning (ptr+1) upward, wrapping;
  - register gnt=onehot(winner) and cmd=req_cmd slice;
  - set ptr=winner; go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (1 cycle):
  - snd_cmd=1; clear counter and the response-seen flag; go to WAIT_SNT.
  - Request to snd_cmd latency is 1 cycle after the IDLE sample cycle.
- WAIT_SNT: on cmd_snt=1, go to WAIT_RESP.
  - cmd_snt is low the cycle after snd_cmd because RemoteComm clears it, so a stale high cannot occur.
- Response detection uses the rising edge of resp_rdy (resp_rdy & ~resp_rdy_q), because rx_rdy is never explicitly cleared.
  - An edge in WAIT_SNT or WAIT_RESP captures resp into resp_out and sets the seen flag.
  - Edges in other states are ignored.
- WAIT_RESP: if seen flag is set, or an edge occurs this cycle, go to DONE with timed_out=0.
- Timeout:
  - The counter increments every cycle in WAIT_SNT and WAIT_RESP.
  - When count == TIMEOUT_CYCLES-1 without completion, go to DONE with timed_out=1 and resp_out=8'h00.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE (1 cycle):
  - done[winner]=1 and timed_out valid.
  - Next cycle: gnt=0, go to IDLE.
- Minimum spacing between transactions is 1 IDLE cycle.
- req is sampled only in IDLE, and req_cmd only at grant.
  - Changes while granted are ignored.
  - A request still high after its done competes again, but others win first.
- gnt and busy are registered state-derived outputs; cmd is unchanged until the next grant.

Decomposition:
- Package remote_arb_pkg holds:
  - arb_state_t enum;
  - CMD_W=16 and RESP_W=8;
  - RESP_TIMEOUT=8'h00.
- Sub-module rr_arbiter (parameter NUM_REQ; inputs req, ptr, en; outputs onehot, idx), purely combinational priority rotation, instantiated once.
- The FSM, counter and edge detector stay in the top.

Test Plan:
- Single request: req=01, req_cmd[0]=16'h2345. Required: snd_cmd pulses 1 cycle after the req sample; cmd=16'h2345. After cmd_snt then a resp_rdy rise with resp=8'hA5: done=01, resp_out=8'hA5, timed_out=0, gnt low the next cycle.
- Round-robin: req=11 held continuously, response 8'hA5 each time. Required grants in order 01, 10, 01, 10; each done pulse goes only to the granted requester.
- Timeout (TIMEOUT_CYCLES=64): cmd_snt rises but no resp_rdy edge. Required: done with timed_out=1 and resp_out=8'h00 exactly 64 cycles after snd_cmd.
- Stale resp_rdy: resp_rdy held high from before the grant. Required: no completion until resp_rdy falls and rises again.
- Mid-flight change: req_cmd[0] changes during WAIT_SNT. Required: cmd keeps the granted value.
- Reset in WAIT_RESP: rst=1 for 1 cycle. Required: all outputs 0 the next cycle, no done pulse, and req=11 then grants requester 0 first.

Source files
------------

// File: rtl/remote_arb_pkg.sv
// Shared types and widths for the RemoteComm command arbiter.
package remote_arb_pkg;

    localparam int CMD_W  = 16;
    localparam int RESP_W = 8;

    localparam logic [RESP_W-1:0] RESP_TIMEOUT = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_SNT,
        WAIT_RESP,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr+1, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (en && !found && req[cand]) begin
                found        = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/remote_cmd_arbiter.sv
// Round-robin sharing of one RemoteComm command channel; one transaction in flight at a time.
module remote_cmd_arbiter
    import remote_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [CMD_W*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [RESP_W-1:0]        resp_out,
    output logic                     timed_out,
    output logic                     busy,
    output logic                     snd_cmd,
    output logic [CMD_W-1:0]         cmd,
    input  logic                     cmd_snt,
    input  logic [RESP_W-1:0]        resp,
    input  logic                     resp_rdy
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   count;
    logic               resp_rdy_q;
    logic               seen;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic [CMD_W-1:0]   win_cmd;
    logic               rise;
    logic               in_wait;
    logic               expired;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req    (req),
        .ptr    (ptr),
        .en     (state == IDLE),
        .onehot (win_onehot),
        .idx    (win_idx)
    );

    always_comb begin
        win_cmd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) win_cmd = req_cmd[CMD_W*i +: CMD_W];
        end
    end

    // resp_rdy is a level that RemoteComm never clears, so only its rising edge marks a new byte.
    assign rise    = resp_rdy & ~resp_rdy_q;
    assign in_wait = (state == WAIT_SNT) || (state == WAIT_RESP);
    assign expired = (count == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NUM_REQ - 1);
            count      <= '0;
            resp_rdy_q <= 1'b0;
            seen       <= 1'b0;
            gnt        <= '0;
            done       <= '0;
            resp_out   <= '0;
            timed_out  <= 1'b0;
            busy       <= 1'b0;
            snd_cmd    <= 1'b0;
            cmd        <= '0;
        end else begin
            // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
            resp_rdy_q <= resp_rdy;
            snd_cmd    <= 1'b0;
            done       <= '0;

            if (in_wait && rise) begin
                resp_out <= resp;
                seen     <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= win_onehot;
                        cmd   <= win_cmd;
                        ptr   <= win_idx;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    snd_cmd <= 1'b1;
                    count   <= '0;
                    seen    <= 1'b0;
                    state   <= WAIT_SNT;
                end
                WAIT_SNT: begin
                    count <= count + 1'b1;
                    if (expired) begin
                        done      <= gnt;
                        timed_out <= 1'b1;
                        resp_out  <= RESP_TIMEOUT;
                        state     <= DONE;
                    end else if (cmd_snt) begin
                        state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    count <= count + 1'b1;
                    // Completion takes precedence over a timeout landing on the same cycle.
                    if (seen || rise) begin
                        done      <= gnt;
                        timed_out <= 1'b0;
                        state     <= DONE;
                    end else if (expired) begin
                        done      <= gnt;
                        timed_out <= 1'b1;
                        resp_out  <= RESP_TIMEOUT;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    gnt       <= '0;
                    busy      <= 1'b0;
                    timed_out <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// Scoreboard bench for remote_cmd_arbiter: two requesters, 64-cycle timeout.
module tb_remote_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [31:0] req_cmd;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  resp_out;
    logic        timed_out;
    logic        busy;
    logic        snd_cmd;
    logic [15:0] cmd;
    logic        cmd_snt;
    logic [7:0]  resp;
    logic        resp_rdy;

    typedef struct packed {
        logic [1:0] who;
        logic [7:0] resp;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    remote_cmd_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_cmd   (req_cmd),
        .gnt       (gnt),
        .done      (done),
        .resp_out  (resp_out),
        .timed_out (timed_out),
        .busy      (busy),
        .snd_cmd   (snd_cmd),
        .cmd       (cmd),
        .cmd_snt   (cmd_snt),
        .resp      (resp),
        .resp_rdy  (resp_rdy)
    );

    always #5 clk = ~clk;

    // Every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done !== 2'b00) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done got done=%b exp no pulse", done);
            end else begin
                e = sb.pop_front();
                if ({done, resp_out, timed_out} !== {e.who, e.resp, e.to}) begin
                    bad++;
                    $display("FAIL sb_done got done=%b resp=%h to=%b exp done=%b resp=%h to=%b",
                             done, resp_out, timed_out, e.who, e.resp, e.to);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_snd();
        int n = 0;
        while (snd_cmd !== 1'b1 && n < 20) begin tick(); n++; end
        if (snd_cmd !== 1'b1) begin
            total++; bad++;
            $display("FAIL snd_cmd_wait got no pulse exp pulse within 20 cycles");
        end
    endtask

    // Plays RemoteComm: cmd_snt after the pulse, then one response-ready rising edge.
    task automatic serve(input logic [7:0] r);
        wait_snd();
        tick();
        cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
        resp = r; resp_rdy = 1'b1; tick();
        resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({gnt, done, busy, snd_cmd, timed_out, cmd, resp_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got gnt=%b done=%b busy=%b snd=%b to=%b cmd=%h resp=%h exp all zero",
                     gnt, done, busy, snd_cmd, timed_out, cmd, resp_out);
        end
    endtask

    task automatic test_single();
        req_cmd = {16'h0000, 16'h2345}; req = 2'b01;
        tick();
        total++;
        if ({gnt, busy, snd_cmd} !== {2'b01, 1'b1, 1'b0}) begin
            bad++; $display("FAIL single_grant got gnt=%b busy=%b snd=%b exp 01 1 0", gnt, busy, snd_cmd);
        end
        sb.push_back('{who: 2'b01, resp: 8'hA5, to: 1'b0});
        req = 2'b00;
        tick();
        total++;
        if ({snd_cmd, cmd} !== {1'b1, 16'h2345}) begin
            bad++; $display("FAIL single_issue got snd=%b cmd=%h exp 1 2345", snd_cmd, cmd);
        end
        serve(8'hA5);
        total++;
        if ({done, resp_out, timed_out} !== {2'b01, 8'hA5, 1'b0}) begin
            bad++; $display("FAIL single_done got done=%b resp=%h to=%b exp 01 a5 0", done, resp_out, timed_out);
        end
        tick();
        total++;
        if ({gnt, busy, done} !== 5'b0) begin
            bad++; $display("FAIL single_release got gnt=%b busy=%b done=%b exp 00 0 00", gnt, busy, done);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [15:0] exp_c;
        do_reset();
        req_cmd = {16'hB002, 16'hA001}; req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            while (gnt === 2'b00 && n < 20) begin tick(); n++; end
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_c = (k % 2 == 0) ? 16'hA001 : 16'hB002;
            total++;
            if ({gnt, cmd} !== {exp_g, exp_c}) begin
                bad++; $display("FAIL rr_grant%0d got gnt=%b cmd=%h exp %b %h", k, gnt, cmd, exp_g, exp_c);
            end
            sb.push_back('{who: exp_g, resp: 8'hA5, to: 1'b0});
            if (k == 3) req = 2'b00;
            serve(8'hA5);
            tick();
        end
    endtask

    task automatic test_timeout();
        int n;
        req_cmd = {16'h0000, 16'h0C0C}; req = 2'b01;
        tick();
        sb.push_back('{who: 2'b01, resp: 8'h00, to: 1'b1});
        req = 2'b00;
        wait_snd();
        n = 0;
        tick(); n++;
        cmd_snt = 1'b1; tick(); n++; cmd_snt = 1'b0;
        while (done === 2'b00 && n < 200) begin tick(); n++; end
        total++;
        if (n != 64) begin
            bad++; $display("FAIL timeout_latency got %0d cycles exp 64", n);
        end
        total++;
        if ({timed_out, resp_out} !== {1'b1, 8'h00}) begin
            bad++; $display("FAIL timeout_flags got to=%b resp=%h exp 1 00", timed_out, resp_out);
        end
        tick();
    endtask

    task automatic test_stale_resp_rdy();
        logic early = 1'b0;
        resp = 8'h5A; resp_rdy = 1'b1;
        tick();
        req = 2'b10;
        tick();
        sb.push_back('{who: 2'b10, resp: 8'h3C, to: 1'b0});
        req = 2'b00;
        wait_snd();
        tick();
        cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done !== 2'b00) early = 1'b1;
        end
        total++;
        if (early !== 1'b0) begin
            bad++; $display("FAIL stale_no_done got early done exp none while resp_rdy held");
        end
        resp_rdy = 1'b0; tick();
        resp = 8'h3C; resp_rdy = 1'b1; tick();
        total++;
        if ({done, resp_out} !== {2'b10, 8'h3C}) begin
            bad++; $display("FAIL stale_done got done=%b resp=%h exp 10 3c", done, resp_out);
        end
        resp_rdy = 1'b0;
        tick();
    endtask

    task automatic test_mid_flight();
        req_cmd = {16'h0000, 16'h1111}; req = 2'b01;
        tick();
        sb.push_back('{who: 2'b01, resp: 8'h77, to: 1'b0});
        req = 2'b00; req_cmd[15:0] = 16'hBEEF;
        wait_snd();
        tick();
        req_cmd[15:0] = 16'hCAFE;
        tick();
        total++;
        if (cmd !== 16'h1111) begin
            bad++; $display("FAIL mid_cmd_hold got cmd=%h exp 1111", cmd);
        end
        cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
        resp = 8'h77; resp_rdy = 1'b1; tick();
        resp_rdy = 1'b0;
        total++;
        if ({done, cmd} !== {2'b01, 16'h1111}) begin
            bad++; $display("FAIL mid_done got done=%b cmd=%h exp 01 1111", done, cmd);
        end
        tick();
    endtask

    task automatic test_reset_in_wait_resp();
        logic stray = 1'b0;
        req_cmd = {16'h0000, 16'h4444}; req = 2'b01;
        tick();
        req = 2'b00;
        wait_snd();
        tick();
        cmd_snt = 1'b1; tick(); cmd_snt = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        total++;
        if ({gnt, done, busy, snd_cmd, timed_out, cmd, resp_out} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs got gnt=%b done=%b busy=%b snd=%b to=%b cmd=%h resp=%h exp all zero",
                     gnt, done, busy, snd_cmd, timed_out, cmd, resp_out);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done !== 2'b00) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) begin
            bad++; $display("FAIL rst_mid_no_done got done pulse exp none after reset");
        end
        req_cmd = {16'h2222, 16'h1234}; req = 2'b11;
        tick();
        total++;
        if ({gnt, cmd} !== {2'b01, 16'h1234}) begin
            bad++; $display("FAIL rst_mid_priority got gnt=%b cmd=%h exp 01 1234", gnt, cmd);
        end
        sb.push_back('{who: 2'b01, resp: 8'h99, to: 1'b0});
        req = 2'b00;
        serve(8'h99);
        tick();
    endtask

    initial begin
        rst = 1'b1; req = '0; req_cmd = '0; cmd_snt = 1'b0; resp = '0; resp_rdy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_stale_resp_rdy();
        test_mid_flight();
        test_reset_in_wait_resp();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_drain got %0d outstanding exp 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
